fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front-end for the 32-bit four-phase core. It generates sequential word addresses, reads instruction words from memory over a req/ack handshake, and buffers them in a small prefetch FIFO. The core pops one instruction per fetch phase through a valid/ready port. A branch or jump redirect flushes the buffer and restarts fetching at a new PC.

## Interface
- `DEPTH`, 4: prefetch FIFO entries. Must be a power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset. Word aligned.

- `clk` in 1: single clock. Every register updates on its rising edge.
- `rst` in 1: reset, **synchronous, active-high**.
- `mem_req` out 1: read request, registered.
- `mem_addr` out 32: byte address of the word being requested, registered. Bits [1:0] are always 0.
- `mem_ack` in 1: memory has accepted the request. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: instruction word returned by memory.
- `redirect` in 1: one-cycle pulse that flushes the buffer and restarts fetching.
- `redirect_pc` in 32: new fetch address. Bits [1:0] are forced to 0.
- `instr_valid` out 1: the FIFO head holds a valid instruction.
- `instr` out 32: head instruction word. Driven to 0 when `instr_valid`=0.
- `instr_pc` out 32: address of the head instruction. Driven to 0 when `instr_valid`=0.
- `instr_ready` in 1: the core takes the head instruction this cycle.

## Operation
- **State machine:** IDLE, WAIT, DISCARD.
  - IDLE: `mem_req`=0. If `count` < DEPTH and `redirect`=0, go to WAIT. On that edge `mem_req` becomes 1 and `mem_addr` becomes `fetch_pc`.
  - WAIT: `mem_req`=1. `mem_addr` is held stable until `mem_ack`.
    - On `mem_ack`: push {`mem_addr`, `mem_rdata`} into the FIFO and set `fetch_pc` = `mem_addr`+4.
    - After the push, if `count_next` < DEPTH, stay in WAIT and present `mem_addr`+4 on the next cycle. This gives back-to-back fetch with no bubble. Otherwise go to IDLE.
  - DISCARD: `mem_req`=1, with the stale address held. On `mem_ack`, drop the data and go to IDLE.
- **FIFO:**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` runs 0..DEPTH.
  - Pop when `instr_valid`&&`instr_ready`. Push and pop in the same cycle leave `count` unchanged.
  - Push never overflows, because a request is issued only when a slot is free.
  - `count_next` includes this cycle's push and pop.
- **Redirect** (highest priority, any state):
  - FIFO flushed: `count`=0, pointers=0. Any pop in the same cycle is ignored.
  - `fetch_pc` = {`redirect_pc`[31:2], 2'b00}.
  - From IDLE: stay in IDLE, then fetch the new PC on the next cycle.
  - From WAIT without `mem_ack`: go to DISCARD. The outstanding request is never withdrawn.
  - From WAIT with `mem_ack` in the same cycle: drop the data and go to IDLE.
  - From DISCARD: stay in DISCARD until ack. Only `fetch_pc` updates.
- **Address arithmetic:** `fetch_pc`+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- **Reset values:** `mem_req`=0, `mem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, state=IDLE, `count`=0, `fetch_pc`=RESET_PC.
- **Reset mid-transfer:** an outstanding request is abandoned and `mem_req` drops on the next edge. The memory model must tolerate this.
- **Latency:**
  - First `mem_req` is asserted 1 cycle after `rst` deasserts.
  - `mem_ack` in cycle k gives `instr_valid`=1 in cycle k+1.
  - A redirect in cycle r gives the redirected `mem_req` in cycle r+2 (from IDLE).
- **Outputs:** `instr`, `instr_pc` and `instr_valid` come combinationally from registered FIFO state. There is no path from `instr_ready` to `mem_req`.
- **Throughput:** with memory that acks every cycle and a core that pops every 4th cycle, the FIFO fills and fetch throttles to 1 request per pop.

## Test plan
- **Reset and linear fetch:** RESET_PC=0x100, memory acks the same cycle, `instr_ready`=1 always. Required: `mem_addr` sequence 0x100, 0x104, 0x108 on consecutive cycles. `instr_pc` trails `mem_addr` by 1 cycle with the matching data.
- **Backpressure and full:** `instr_ready`=0 with immediate ack. Required: exactly DEPTH=4 acks, then `mem_req`=0 and `count`=4. Raise `instr_ready` for 1 cycle. Required: one pop, then one new request at the next sequential address.
- **Redirect while WAIT:** memory acks 3 cycles after request. Pulse `redirect` with `redirect_pc`=0x2002 mid-wait. Required: the stale ack data is never presented, the FIFO is empty, and the next request is at 0x2000.
- **Redirect coinciding with `mem_ack` and pop:** required: `count`=0 after the edge, no stale push, state IDLE, and the next `mem_addr` = the redirect target.
- **Wrap and pointer wrap:** RESET_PC=0xFFFF_FFF8 with a 10-instruction stream. Required: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and so on. FIFO order is preserved across at least 2 pointer wraps.
- **Reset mid-WAIT:** assert `rst` for 1 cycle while `mem_req`=1 with no ack. Required: `mem_req`=0 on the next edge, `instr_valid`=0, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end. It issues sequential word reads
// over a req/ack handshake, buffers the returned words with their addresses
// in a small prefetch FIFO, and hands them to the core through valid/ready.
// A redirect flushes the FIFO and restarts fetching at a new PC.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no request outstanding; issue one when the FIFO has room
// S_WAIT    | request outstanding at mem_addr; push the word on ack
// S_DISCARD | request outstanding but stale after a redirect; drop on ack

module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [31:0]      START_PC = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [31:0]        buf_data [DEPTH];
  logic [31:0]        buf_pc   [DEPTH];
  logic               push;
  logic               pop;

  // A redirect cancels both the pop and the push of its cycle.
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign push        = (state == S_WAIT) && mem_ack && !redirect;
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);
  assign instr       = instr_valid ? buf_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : '0;

  // FIFO storage: capture the acked word together with its address.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= mem_rdata;
      buf_pc[wr_ptr]   <= mem_addr;
    end
  end

  // Fetch FSM, request outputs and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= START_PC;
      fetch_pc <= START_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      case (state)
        S_IDLE: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
        S_WAIT, S_DISCARD: begin
          // The outstanding request is never withdrawn; wait out its ack.
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
          end else begin
            state <= S_DISCARD;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case (state)
        S_IDLE: begin
          if (count < FULL) begin
            state    <= S_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            fetch_pc <= mem_addr + 32'd4;
            if (count_next < FULL) begin
              mem_addr <= mem_addr + 32'd4;
            end else begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by a randomized run, checked
// against a queue-based model of the expected instruction stream.

module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_chk = 0;
  int n_err = 0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Memory model: each request is acked after a latency of 0..max_lat cycles.
  int max_lat = 0;
  bit fix_lat = 1'b1;
  bit hold    = 1'b0;
  bit armed   = 1'b0;
  int mem_cnt = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_req) begin
        armed   = 1'b0;
        mem_ack = 1'b0;
      end else if (hold) begin
        mem_ack = 1'b0;
      end else begin
        if (!armed) begin
          armed   = 1'b1;
          mem_cnt = fix_lat ? max_lat : int'($urandom_range(0, max_lat));
        end
        if (mem_cnt == 0) begin
          mem_ack = 1'b1;
          armed   = 1'b0;
        end else begin
          mem_ack = 1'b0;
          mem_cnt--;
        end
      end
      mem_rdata = mem_ack ? mem_word(mem_addr) : $urandom;
    end
  end

  // Reference model: the buffered instructions are the consecutive words
  // fetched since the last reset/redirect that the core has not yet taken.
  logic [31:0] q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          discard = 1'b0;
  int          gap = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_pc    = RESET_PC;
        discard = 1'b0;
        gap     = 0;
      end else begin
        chk("valid", 32'(instr_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("instr_pc", instr_pc, q[0]);
          chk("instr", instr, mem_word(q[0]));
        end else begin
          chk("pc_zero", instr_pc, 0);
          chk("instr_zero", instr, 0);
        end
        chk("align", 32'(mem_addr[1:0]), 0);
        if (discard) chk("discard_req", 32'(mem_req), 1);
        else if (mem_req) chk("req_addr", mem_addr, m_pc);
        if (q.size() == DEPTH) chk("full_noreq", 32'(mem_req), 0);
        if (redirect) begin
          discard = mem_req && !mem_ack;
          q.delete();
          m_pc = redirect_pc & 32'hFFFF_FFFC;
          gap  = 0;
        end else begin
          if (!mem_req && q.size() < DEPTH) gap++;
          else gap = 0;
          chk("req_gap", 32'(gap > 1), 0);
          if (q.size() != 0 && instr_ready) void'(q.pop_front());
          if (mem_req && mem_ack) begin
            if (discard) discard = 1'b0;
            else begin
              q.push_back(m_pc);
              m_pc = m_pc + 32'd4;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    int found;
    int mode;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", mem_addr, RESET_PC);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);

    // Address wrap from the reset PC, then a longer stream across pointer wraps.
    step();
    instr_ready = 1'b1; rst = 1'b0;
    step(); @(negedge clk);
    chk("first_req", 32'(mem_req), 1);
    chk("wrap_a0", mem_addr, 32'hFFFF_FFF8);
    step(); @(negedge clk);
    chk("wrap_a1", mem_addr, 32'hFFFF_FFFC);
    chk("wrap_p0", instr_pc, 32'hFFFF_FFF8);
    step(); @(negedge clk);
    chk("wrap_a2", mem_addr, 32'h0000_0000);
    chk("wrap_p1", instr_pc, 32'hFFFF_FFFC);
    fix_lat = 1'b0; max_lat = 2;
    repeat (30) begin step(); instr_ready = 1'($urandom_range(0, 1)); end

    // Linear fetch at 0x100 with zero-latency memory.
    fix_lat = 1'b1; max_lat = 0; instr_ready = 1'b1;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step(); redirect = 1'b0;
    step(); @(negedge clk);
    chk("lin_req", 32'(mem_req), 1);
    chk("lin_a0", mem_addr, 32'h100);
    step(); @(negedge clk);
    chk("lin_a1", mem_addr, 32'h104);
    chk("lin_p0", instr_pc, 32'h100);
    chk("lin_d0", instr, mem_word(32'h100));
    step(); @(negedge clk);
    chk("lin_a2", mem_addr, 32'h108);
    chk("lin_p1", instr_pc, 32'h104);

    // Backpressure: fill, then release exactly one instruction.
    step();
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    step(); redirect = 1'b0;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
      step();
    end
    @(negedge clk);
    chk("full_acks", acks, DEPTH);
    chk("full_req", 32'(mem_req), 0);
    chk("full_valid", 32'(instr_valid), 1);
    chk("full_cnt", q.size(), DEPTH);
    step(); instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    @(negedge clk);
    chk("pop_req0", 32'(mem_req), 0);
    chk("pop_pc", instr_pc, 32'h304);
    step(); @(negedge clk);
    chk("pop_req1", 32'(mem_req), 1);
    chk("pop_addr", mem_addr, 32'h310);
    step(); @(negedge clk);
    chk("refull_req", 32'(mem_req), 0);

    // Redirect while a slow request is outstanding.
    step();
    fix_lat = 1'b1; max_lat = 3; instr_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && armed && !mem_ack) begin found = 1; break; end
      step();
    end
    chk("rw_found", found, 1);
    redirect = 1'b1; redirect_pc = 32'h2002;
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("rw_valid", 32'(instr_valid), 0);
    chk("rw_discard", 32'(mem_req), 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step(); @(negedge clk);
      if (!mem_req) begin found = 1; break; end
    end
    chk("rw_idle", found, 1);
    chk("rw_empty", 32'(instr_valid), 0);
    step(); @(negedge clk);
    chk("rw_req", 32'(mem_req), 1);
    chk("rw_addr", mem_addr, 32'h2000);

    // Redirect coinciding with an ack and a pop.
    step();
    max_lat = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid && mem_req && mem_ack) begin found = 1; break; end
      step();
    end
    chk("rc_found", found, 1);
    redirect = 1'b1; redirect_pc = 32'h4000;
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("rc_valid", 32'(instr_valid), 0);
    chk("rc_req0", 32'(mem_req), 0);
    step(); @(negedge clk);
    chk("rc_req1", 32'(mem_req), 1);
    chk("rc_addr", mem_addr, 32'h4000);

    // Reset while a request is waiting for an ack.
    step(); hold = 1'b1;
    step(); step(); @(negedge clk);
    chk("mr_wait", 32'(mem_req), 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("mr_req0", 32'(mem_req), 0);
    chk("mr_valid", 32'(instr_valid), 0);
    step(); @(negedge clk);
    chk("mr_req1", 32'(mem_req), 1);
    chk("mr_addr", mem_addr, RESET_PC);
    step(); hold = 1'b0;

    // Randomized run: latency, core readiness, redirects and resets.
    fix_lat = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc % 200 == 0) max_lat = int'($urandom_range(0, 3));
      mode = (cyc / 500) % 3;
      if (mode == 0)      instr_ready = ($urandom % 4) != 0;
      else if (mode == 1) instr_ready = (cyc % 4) == 0;
      else                instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom % 40) == 0;
      redirect_pc = $urandom;
      rst         = ($urandom % 600) == 0;
    end
    step();
    rst = 1'b0; redirect = 1'b0;
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
